// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / stall controller: load-use, branch-on-load, multi-cycle divide and memory wait.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_STATS_EN.
module pipeline_ctrl #(
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_branch_ID,
  input  logic [4:0]  raddr_1_ID,
  input  logic [4:0]  raddr_2_ID,
  input  logic        re_1_ID,
  input  logic        re_2_ID,
  input  logic [4:0]  target_EX,
  input  logic [4:0]  target_MEM,
  input  logic        is_load_EX,
  input  logic        is_load_MEM,
  input  logic        div_start_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ack,
  output logic [4:0]  stall,
  output logic        bubble_EX,
  output logic        bubble_MEM,
  output logic        bubble_WB,
  output logic        div_busy,
  output logic        div_done,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES);
  localparam logic [7:0] TO_MAX   = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TO_HIT   = 8'(MEM_TIMEOUT - 1);

  logic [1:0] r_state, w_state_nx;
  logic [5:0] r_div_cnt, w_div_cnt_nx;
  logic [7:0] r_wait_cnt;

  logic w_mem_stall, w_load_use, w_br_haz, w_div_fin;

  function automatic logic src_hit(input logic re, input logic [4:0] a, input logic [4:0] t);
    return re && (a != 5'd0) && (a == t);
  endfunction

  assign w_mem_stall = mem_req_MEM && !mem_ack;
  assign w_load_use  = is_load_EX &&
                       (src_hit(re_1_ID, raddr_1_ID, target_EX) || src_hit(re_2_ID, raddr_2_ID, target_EX));
  // ALU results are forwarded into ID; only a load still in MEM blocks a branch
  assign w_br_haz    = is_branch_ID && is_load_MEM &&
                       (src_hit(re_1_ID, raddr_1_ID, target_MEM) || src_hit(re_2_ID, raddr_2_ID, target_MEM));
  assign w_div_fin   = (r_state == S_DIV) && (r_div_cnt == DIV_LAST) && !w_mem_stall;

  always_comb begin
    w_state_nx   = r_state;
    w_div_cnt_nx = r_div_cnt;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_nx = S_WAIT;
        end else if (div_start_EX) begin
          w_state_nx   = S_DIV;
          w_div_cnt_nx = 6'd1;
        end
      end
      S_DIV: begin
        if (w_div_fin) begin
          w_state_nx   = S_RUN;
          w_div_cnt_nx = 6'd0;
        end else if (r_div_cnt != DIV_LAST) begin
          w_div_cnt_nx = r_div_cnt + 6'd1;
        end
      end
      S_WAIT: begin
        if (!w_mem_stall) w_state_nx = S_RUN;
      end
      default: begin
        w_state_nx   = S_RUN;
        w_div_cnt_nx = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_div_cnt  <= 6'd0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nx;
      r_div_cnt <= w_div_cnt_nx;
      // counts completed wait cycles; saturation keeps the timeout a single pulse
      if (w_mem_stall) begin
        if (r_wait_cnt != TO_MAX) r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    stall       = 5'b00000;
    bubble_EX   = 1'b0;
    bubble_MEM  = 1'b0;
    bubble_WB   = 1'b0;
    div_busy    = 1'b0;
    div_done    = 1'b0;
    mem_timeout = 1'b0;
    if (!rst) begin
      div_busy    = (r_state == S_DIV);
      div_done    = w_div_fin;
      mem_timeout = w_mem_stall && (r_wait_cnt == TO_HIT);
      if (w_mem_stall) begin
        stall     = 5'b01111;
        bubble_WB = 1'b1;
      end else if (r_state == S_DIV) begin
        stall      = 5'b00111;
        bubble_MEM = 1'b1;
      end else if (r_state == S_RUN && (w_br_haz || w_load_use)) begin
        stall     = 5'b00011;
        bubble_EX = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk) begin
    if (rst)           r_stall_cycles <= 32'd0;
    else if (stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = rst ? 32'd0 : r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes model responses, negedge monitor compares.
module tb_pipeline_ctrl;
  localparam int DIV_CYCLES  = 32;
  localparam int MEM_TIMEOUT = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, is_branch_ID, re_1_ID, re_2_ID, is_load_EX, is_load_MEM;
  logic        div_start_EX, mem_req_MEM, mem_ack;
  logic [4:0]  raddr_1_ID, raddr_2_ID, target_EX, target_MEM;
  logic [4:0]  stall;
  logic        bubble_EX, bubble_MEM, bubble_WB, div_busy, div_done, mem_timeout;
  logic [31:0] stall_cycles;

  pipeline_ctrl #(.DIV_CYCLES(DIV_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .is_branch_ID(is_branch_ID),
    .raddr_1_ID(raddr_1_ID), .raddr_2_ID(raddr_2_ID), .re_1_ID(re_1_ID), .re_2_ID(re_2_ID),
    .target_EX(target_EX), .target_MEM(target_MEM), .is_load_EX(is_load_EX), .is_load_MEM(is_load_MEM),
    .div_start_EX(div_start_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .stall(stall), .bubble_EX(bubble_EX), .bubble_MEM(bubble_MEM), .bubble_WB(bubble_WB),
    .div_busy(div_busy), .div_done(div_done), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic       rst, br;
    logic [4:0] a1, a2;
    logic       re1, re2;
    logic [4:0] tex, tmem;
    logic       lex, lmem, ds, mreq, mack;
  } stim_t;

  typedef struct packed {
    logic [4:0]  stall;
    logic        bex, bmem, bwb, busy, done, to;
    logic [31:0] sc;
  } resp_t;

  resp_t q[$];
  int n_checks = 0, n_err = 0;
  int cnt_busy = 0, cnt_done = 0, cnt_to = 0;

  // reference model state: plain cycle counts, not an FSM
  bit m_div = 0, m_wait_run = 0;
  int m_el = 0, m_wait = 0;
  int unsigned m_sc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic re, input logic [4:0] a, input logic [4:0] t);
    return re && a != 0 && a == t;
  endfunction

  task automatic apply(input stim_t s);
    resp_t e;
    bit ms, hz, dn;
    int cur;
    @(posedge clk); #1;
    rst = s.rst; is_branch_ID = s.br; raddr_1_ID = s.a1; raddr_2_ID = s.a2;
    re_1_ID = s.re1; re_2_ID = s.re2; target_EX = s.tex; target_MEM = s.tmem;
    is_load_EX = s.lex; is_load_MEM = s.lmem; div_start_EX = s.ds;
    mem_req_MEM = s.mreq; mem_ack = s.mack;
    e = '0;
    if (s.rst) begin
      m_div = 0; m_wait_run = 0; m_el = 0; m_wait = 0; m_sc = 0;
    end else begin
      ms  = s.mreq && !s.mack;
      hz  = (s.lex && (hit(s.re1, s.a1, s.tex) || hit(s.re2, s.a2, s.tex))) ||
            (s.br && s.lmem && (hit(s.re1, s.a1, s.tmem) || hit(s.re2, s.a2, s.tmem)));
      cur = ms ? m_wait + 1 : 0;
      dn  = m_div && m_el >= DIV_CYCLES && !ms;
      if (ms)                     begin e.stall = 5'b01111; e.bwb  = 1; end
      else if (m_div)             begin e.stall = 5'b00111; e.bmem = 1; end
      else if (!m_wait_run && hz) begin e.stall = 5'b00011; e.bex  = 1; end
      e.busy = m_div;
      e.done = dn;
      e.to   = (cur == MEM_TIMEOUT);
`ifdef PIPE_CTRL_STATS_EN
      e.sc = m_sc;
      if (e.stall[0]) m_sc++;
`endif
      m_wait = cur;
      if (m_div) begin
        if (dn) m_div = 0; else m_el++;
      end else if (m_wait_run) begin
        if (!ms) m_wait_run = 0;
      end else if (ms) begin
        m_wait_run = 1;
      end else if (s.ds) begin
        m_div = 1; m_el = 1;
      end
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",        32'(stall),       32'(e.stall));
        chk("bubble_EX",    32'(bubble_EX),   32'(e.bex));
        chk("bubble_MEM",   32'(bubble_MEM),  32'(e.bmem));
        chk("bubble_WB",    32'(bubble_WB),   32'(e.bwb));
        chk("div_busy",     32'(div_busy),    32'(e.busy));
        chk("div_done",     32'(div_done),    32'(e.done));
        chk("mem_timeout",  32'(mem_timeout), 32'(e.to));
        chk("stall_cycles", stall_cycles,     e.sc);
        if (div_busy)    cnt_busy++;
        if (div_done)    cnt_done++;
        if (mem_timeout) cnt_to++;
      end
    end
  end

  initial begin : driver
    stim_t s, idle;
    idle = '0;
    rst = 1; is_branch_ID = 0; raddr_1_ID = 0; raddr_2_ID = 0; re_1_ID = 0; re_2_ID = 0;
    target_EX = 0; target_MEM = 0; is_load_EX = 0; is_load_MEM = 0;
    div_start_EX = 0; mem_req_MEM = 0; mem_ack = 0;

    s = idle; s.rst = 1;
    apply(s); apply(s);
    apply(idle);

    // load-use, then the same with a zero target
    s = idle; s.lex = 1; s.tex = 5; s.a1 = 5; s.re1 = 1;
    apply(s);
    s.tex = 0; apply(s);
    // branch on a load in MEM, then on an ALU result
    s = idle; s.br = 1; s.a2 = 9; s.re2 = 1; s.lmem = 1; s.tmem = 9;
    apply(s);
    s.lmem = 0; apply(s);

    // plain divide
    apply(idle);
    cnt_busy = 0; cnt_done = 0;
    s = idle; s.ds = 1; apply(s);
    repeat (35) apply(idle);
    apply(idle);
    chk("div_busy_len", 32'(cnt_busy), 32'(DIV_CYCLES));
    chk("div_done_cnt", 32'(cnt_done), 32'd1);

    // long memory wait through the timeout
    cnt_to = 0;
    s = idle; s.mreq = 1;
    repeat (300) apply(s);
    s.mack = 1; apply(s);
    apply(idle); apply(idle);
    chk("timeout_cnt", 32'(cnt_to), 32'd1);

    // memory stall overlapping the end of a divide
    cnt_done = 0;
    s = idle; s.ds = 1; apply(s);
    repeat (29) apply(idle);
    s = idle; s.mreq = 1;
    repeat (11) apply(s);
    s.mack = 1; apply(s);
    repeat (3) apply(idle);
    chk("overlap_done_cnt", 32'(cnt_done), 32'd1);

    // reset in the middle of a divide
    cnt_done = 0;
    s = idle; s.ds = 1; apply(s);
    repeat (9) apply(idle);
    s = idle; s.rst = 1; apply(s);
    repeat (40) apply(idle);
    chk("abort_done_cnt", 32'(cnt_done), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.br   = ($urandom_range(0, 9) < 3);
      s.a1   = 5'($urandom_range(0, 3));
      s.a2   = 5'($urandom_range(0, 3));
      s.re1  = 1'($urandom);
      s.re2  = 1'($urandom);
      s.tex  = 5'($urandom_range(0, 3));
      s.tmem = 5'($urandom_range(0, 3));
      s.lex  = 1'($urandom);
      s.lmem = 1'($urandom);
      s.ds   = ($urandom_range(0, 9) == 0);
      s.mreq = ($urandom_range(0, 9) < 3);
      s.mack = ($urandom_range(0, 9) < 4);
      apply(s);
    end

    apply(idle);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
